// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment stage.
package lsu_pkg;

  // RV32I load/store width encodings
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_align_load_extract.sv
// Selects the addressed byte/half of a RAM word and sign- or zero-extends it.
// Purely combinational so a future cache refill path can share it.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // lane select followed by width-dependent extension
  always_comb begin
    case (i_lane)
      2'd0:    byte_sel = i_word[7:0];
      2'd1:    byte_sel = i_word[15:8];
      2'd2:    byte_sel = i_word[23:16];
      default: byte_sel = i_word[31:24];
    endcase
    half_sel = i_lane[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    o_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    o_data = i_word;
      F3_BU:   o_data = {24'd0, byte_sel};
      F3_HU:   o_data = {16'd0, half_sel};
      default: o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_align.sv
// Load/store alignment stage in front of the byte-lane data RAM.
//   state   | meaning
//   IDLE    | ready for a request; RAM strobes driven on the accept cycle
//   RD_WAIT | load issued, RAM word arrives this cycle and is extracted
//   RESP    | one-cycle response pulse with rdata and fault flags
module lsu_mem_align
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH:0]   i_req_addr,
  input  logic [DATA_WIDTH:0]   i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH:0]   o_rsp_rdata,
  output logic                  o_rsp_misaligned,
  output logic                  o_rsp_illegal,
  output logic                  o_read_req,
  output logic [ADDR_WIDTH:0]   o_read_addr,
  input  logic [DATA_WIDTH:0]   i_read_data,
  output logic                  o_write_enable,
  output logic [3:0]            o_byte_enable,
  output logic [ADDR_WIDTH:0]   o_write_addr,
  output logic [DATA_WIDTH:0]   o_write_data
);

  lsu_state_t          state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          lane_q, lane_d;
  logic [DATA_WIDTH:0] rdata_q, rdata_d;
  logic                mis_q, mis_d;
  logic                ill_q, ill_d;

  logic                accept;
  logic                illegal;
  logic                misaligned;
  logic                fault;
  logic [3:0]          be;
  logic [DATA_WIDTH:0] load_data;

  assign o_req_ready = (state_q == IDLE) && rst;
  assign accept      = i_req_valid && o_req_ready && clk_en;

  // request classification; illegal wins over misaligned
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (i_req_funct3)
      F3_B:         illegal = 1'b0;
      F3_H:         misaligned = i_req_addr[0];
      F3_W:         misaligned = (i_req_addr[1:0] != 2'b00);
      F3_BU:        illegal = i_req_we;
      F3_HU: begin
        illegal    = i_req_we;
        misaligned = i_req_addr[0];
      end
      default:      illegal = 1'b1;
    endcase
    fault = illegal || misaligned;
  end

  // store lane enables and lane-replicated write data
  always_comb begin
    be           = 4'b0000;
    o_write_data = i_req_wdata;
    case (i_req_funct3)
      F3_B: begin
        be           = 4'b0001 << i_req_addr[1:0];
        o_write_data = {4{i_req_wdata[7:0]}};
      end
      F3_H: begin
        be           = i_req_addr[1] ? 4'b1100 : 4'b0011;
        o_write_data = {2{i_req_wdata[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign o_write_enable = accept && i_req_we && !fault;
  assign o_read_req     = accept && !i_req_we && !fault;
  assign o_byte_enable  = o_write_enable ? be : 4'b0000;
  assign o_read_addr    = {2'b00, i_req_addr[ADDR_WIDTH:2]};
  assign o_write_addr   = {2'b00, i_req_addr[ADDR_WIDTH:2]};

  lsu_load_extract u_extract (
    .i_funct3 (funct3_q),
    .i_lane   (lane_q),
    .i_word   (i_read_data),
    .o_data   (load_data)
  );

  // next-state and response register logic; everything holds while clk_en is low
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    lane_d   = lane_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    ill_d    = ill_q;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (fault) begin
              state_d = RESP;
              ill_d   = illegal;
              mis_d   = misaligned && !illegal;
              rdata_d = '0;
            end else if (i_req_we) begin
              state_d = RESP;
              rdata_d = '0;
            end else begin
              state_d  = RD_WAIT;
              funct3_d = i_req_funct3;
              lane_d   = i_req_addr[1:0];
            end
          end
        end
        RD_WAIT: begin
          rdata_d = load_data;
          state_d = RESP;
        end
        RESP: begin
          state_d = IDLE;
          rdata_d = '0;
          mis_d   = 1'b0;
          ill_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      funct3_q <= 3'd0;
      lane_q   <= 2'd0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      lane_q   <= lane_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
    end
  end

  assign o_rsp_valid      = (state_q == RESP);
  assign o_rsp_rdata      = rdata_q;
  assign o_rsp_misaligned = mis_q;
  assign o_rsp_illegal    = ill_q;

endmodule
